// File: rtl/vmem_pkg.sv
// Shared state encoding and default widths for the video RAM image loader.
package vmem_pkg;

    localparam int VMEM_ADDR_W = 11;
    localparam int VMEM_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } vmem_ld_state_t;

endpackage

// File: rtl/vmem_checksum.sv
// Running 16-bit sum of the words written into video RAM.
// Latency: an accepted word shows in sum on the following cycle.
// Backpressure: none; accumulates only on add_en cycles, clear wins over add.
module vmem_checksum
    import vmem_pkg::*;
#(
    parameter int DATA_W = VMEM_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              add_en,
    input  logic [DATA_W-1:0] add_data,
    output logic [15:0]       sum
);

    logic [15:0] add_ext;

    always_comb begin
        add_ext = 16'(add_data);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum <= '0;
        end else if (clear) begin
            sum <= '0;
        end else if (add_en) begin
            sum <= sum + add_ext;
        end
    end

endmodule

// File: rtl/vmem_loader.sv
// Copies image ROM words 0..LAST_ADDR into the video RAM write port; optional VMEM_LOADER_CHECKSUM_EN adds checksum_o.
// Latency: busy the cycle after start; ROM_LATENCY+1 cycles per word, then a one-cycle done pulse.
// Backpressure: wr_en_i low stalls in WRITE holding address/data; abort_i returns to idle at once.
module vmem_loader
    import vmem_pkg::*;
#(
    parameter int ADDR_W      = VMEM_ADDR_W,
    parameter int DATA_W      = VMEM_DATA_W,
    parameter int LAST_ADDR   = 2047,
    parameter int ROM_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic              wr_en_i,
    output logic [ADDR_W-1:0] rom_ad_o,
    input  logic [DATA_W-1:0] rom_data_i,
    output logic              ram_ce_o,
    output logic [ADDR_W-1:0] ram_ad_o,
    output logic [DATA_W-1:0] ram_data_o,
    output logic              busy_o,
    output logic              done_o
`ifdef VMEM_LOADER_CHECKSUM_EN
    ,
    output logic [15:0]       checksum_o
`endif
);

    localparam int                CNT_W     = $clog2(ROM_LATENCY + 1);
    localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(ROM_LATENCY);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(LAST_ADDR);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

    vmem_ld_state_t    state;
    vmem_ld_state_t    state_nxt;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] ram_ad_q;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] data_q;
    logic              start_acc;
    logic              fetch_last;
    logic              write_go;
    logic              last_word;

    // Abort outranks start, the ROM latch and the write itself.
    always_comb begin
        start_acc  = (state == IDLE) && start_i && !abort_i;
        fetch_last = (state == FETCH) && !abort_i && (cnt == CNT_ONE);
        write_go   = (state == WRITE) && wr_en_i && !abort_i;
        last_word  = (addr == ADDR_LAST);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start_acc) state_nxt = FETCH;
            end
            FETCH: begin
                if (abort_i)         state_nxt = IDLE;
                else if (fetch_last) state_nxt = WRITE;
            end
            WRITE: begin
                if (abort_i)       state_nxt = IDLE;
                else if (write_go) state_nxt = last_word ? DONE : FETCH;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ram_ad_q remembers the last WRITE address so it survives the increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr     <= '0;
            cnt      <= '0;
            data_q   <= '0;
            ram_ad_q <= '0;
        end else begin
            if (start_acc) begin
                addr <= '0;
                cnt  <= CNT_LOAD;
            end else if ((state == FETCH) && !abort_i) begin
                cnt <= cnt - CNT_ONE;
                if (fetch_last) data_q <= rom_data_i;
            end else if (write_go && !last_word) begin
                addr <= addr + ADDR_ONE;
                cnt  <= CNT_LOAD;
            end
            if (state == WRITE) ram_ad_q <= addr;
        end
    end

    always_comb begin
        busy_o   = 1'b0;
        done_o   = 1'b0;
        ram_ce_o = 1'b0;
        ram_ad_o = ram_ad_q;
        case (state)
            FETCH: busy_o = 1'b1;
            WRITE: begin
                busy_o   = 1'b1;
                ram_ce_o = write_go;
                ram_ad_o = addr;
            end
            DONE:    done_o = 1'b1;
            default: ;
        endcase
    end

    assign rom_ad_o   = addr;
    assign ram_data_o = data_q;

`ifdef VMEM_LOADER_CHECKSUM_EN
    vmem_checksum #(
        .DATA_W (DATA_W)
    ) u_checksum (
        .clk      (clk),
        .rst      (rst),
        .clear    (start_acc),
        .add_en   (ram_ce_o),
        .add_data (ram_data_o),
        .sum      (checksum_o)
    );
`endif

endmodule

// File: tb/tb_vmem_loader.sv
// Two loader instances (8 words / latency 1 and 4 words / latency 3) against a timing-level scoreboard model.
module tb_vmem_loader;

    localparam int AW    = 11;
    localparam int DW    = 8;
    localparam int LA_A  = 7;
    localparam int LAT_A = 1;
    localparam int LA_B  = 3;
    localparam int LAT_B = 3;

    typedef struct {
        int c;
        int a;
        int d;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic wr_en = 1'b0;
    logic b_ff = 1'b1;

    logic [AW-1:0] rom_ad_a, rom_ad_b, ram_ad_a, ram_ad_b, pipe_b0, pipe_b1;
    logic [DW-1:0] rom_data_a, rom_data_b, ram_data_a, ram_data_b;
    logic          ce_a, ce_b, busy_a, busy_b, done_a, done_b;
`ifdef VMEM_LOADER_CHECKSUM_EN
    logic [15:0]   cs_a, cs_b;
    logic [15:0]   cs_done_a = '0;
    logic [15:0]   cs_done_b = '0;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int rise_a = 0;
    int done_at_a = 0;
    int done_cnt_a = 0;
    logic prev_busy_a = 1'b0;
    wr_t wq[$];
    wr_t wqb[$];

    // scoreboard state, index 0 = instance A, 1 = instance B
    bit          m_act[2];
    int          m_k[2];
    int          m_open[2];
    int          m_done[2];
    int          m_cur[2];
    int          m_lad[2];
    int          m_ldat[2];
    logic [15:0] m_sum[2];

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rom_word(input int i, input int a, input logic ff);
        if (i == 0) return 8'(a + 16);
        return ff ? 8'hFF : 8'(a * 29 + 3);
    endfunction

    function automatic int lat_of(input int i);
        return (i == 0) ? LAT_A : LAT_B;
    endfunction

    function automatic int last_of(input int i);
        return (i == 0) ? LA_A : LA_B;
    endfunction

    assign rom_data_a = rom_word(0, int'(rom_ad_a), b_ff);
    assign rom_data_b = rom_word(1, int'(pipe_b1), b_ff);

    // ROM B answers two clocks after its address, i.e. within ROM_LATENCY=3 cycles.
    always @(posedge clk) begin
        pipe_b0 <= rom_ad_b;
        pipe_b1 <= pipe_b0;
    end

    vmem_loader #(.ADDR_W(AW), .DATA_W(DW), .LAST_ADDR(LA_A), .ROM_LATENCY(LAT_A)) dut_a (
        .clk(clk), .rst(rst), .start_i(start), .abort_i(abort), .wr_en_i(wr_en),
        .rom_ad_o(rom_ad_a), .rom_data_i(rom_data_a), .ram_ce_o(ce_a), .ram_ad_o(ram_ad_a),
        .ram_data_o(ram_data_a), .busy_o(busy_a), .done_o(done_a)
`ifdef VMEM_LOADER_CHECKSUM_EN
        , .checksum_o(cs_a)
`endif
    );

    vmem_loader #(.ADDR_W(AW), .DATA_W(DW), .LAST_ADDR(LA_B), .ROM_LATENCY(LAT_B)) dut_b (
        .clk(clk), .rst(rst), .start_i(start), .abort_i(abort), .wr_en_i(wr_en),
        .rom_ad_o(rom_ad_b), .rom_data_i(rom_data_b), .ram_ce_o(ce_b), .ram_ad_o(ram_ad_b),
        .ram_data_o(ram_data_b), .busy_o(busy_b), .done_o(done_b)
`ifdef VMEM_LOADER_CHECKSUM_EN
        , .checksum_o(cs_b)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: word k is written in the first cycle >= m_open with wr_en high and no abort.
    always @(negedge clk) begin
        logic [AW-1:0] g_rom[2];
        logic [AW-1:0] g_rad[2];
        logic [DW-1:0] g_dat[2];
        logic          g_ce[2];
        logic          g_busy[2];
        logic          g_done[2];
        logic          in_wr, in_done, e_ce;
        g_rom[0] = rom_ad_a;   g_rom[1] = rom_ad_b;
        g_rad[0] = ram_ad_a;   g_rad[1] = ram_ad_b;
        g_dat[0] = ram_data_a; g_dat[1] = ram_data_b;
        g_ce[0] = ce_a;        g_ce[1] = ce_b;
        g_busy[0] = busy_a;    g_busy[1] = busy_b;
        g_done[0] = done_a;    g_done[1] = done_b;
        for (int i = 0; i < 2; i++) begin
            if (!rst) begin
                m_act[i] = 1'b0; m_done[i] = -1; m_cur[i] = 0;
                m_lad[i] = 0; m_ldat[i] = 0; m_sum[i] = '0;
                chk(i == 0 ? "rst_busy_a" : "rst_busy_b", g_busy[i], 0);
                chk(i == 0 ? "rst_ce_a" : "rst_ce_b", g_ce[i], 0);
                chk(i == 0 ? "rst_ram_ad_a" : "rst_ram_ad_b", g_rad[i], 0);
            end else begin
                in_done = (m_done[i] == cyc);
                in_wr   = m_act[i] && (cyc >= m_open[i]);
                e_ce    = in_wr && wr_en && !abort;
                if (in_wr) begin
                    m_lad[i]  = m_k[i];
                    m_ldat[i] = int'(rom_word(i, m_k[i], b_ff));
                end
                chk(i == 0 ? "busy_a" : "busy_b", g_busy[i], m_act[i]);
                chk(i == 0 ? "done_a" : "done_b", g_done[i], in_done);
                chk(i == 0 ? "ce_a" : "ce_b", g_ce[i], e_ce);
                chk(i == 0 ? "ram_ad_a" : "ram_ad_b", g_rad[i], m_lad[i]);
                chk(i == 0 ? "ram_data_a" : "ram_data_b", g_dat[i], m_ldat[i]);
                chk(i == 0 ? "rom_ad_a" : "rom_ad_b", g_rom[i], m_cur[i]);
`ifdef VMEM_LOADER_CHECKSUM_EN
                chk(i == 0 ? "checksum_a" : "checksum_b", (i == 0) ? cs_a : cs_b, m_sum[i]);
`endif
                if (e_ce) m_sum[i] = m_sum[i] + 16'(m_ldat[i]);
                if (m_act[i]) begin
                    if (abort) begin
                        m_act[i] = 1'b0;
                    end else if (e_ce) begin
                        if (m_k[i] == last_of(i)) begin
                            m_act[i]  = 1'b0;
                            m_done[i] = cyc + 1;
                        end else begin
                            m_k[i]    = m_k[i] + 1;
                            m_cur[i]  = m_k[i];
                            m_open[i] = cyc + 1 + lat_of(i);
                        end
                    end
                end else if (!in_done && start && !abort) begin
                    m_act[i] = 1'b1; m_k[i] = 0; m_cur[i] = 0;
                    m_open[i] = cyc + 1 + lat_of(i);
                    m_sum[i] = '0;
                end
            end
        end
        if (rst) begin
            if (ce_a) wq.push_back('{cyc, int'(ram_ad_a), int'(ram_data_a)});
            if (ce_b) wqb.push_back('{cyc, int'(ram_ad_b), int'(ram_data_b)});
            if (busy_a && !prev_busy_a) rise_a = cyc;
            if (done_a) begin
                done_at_a = cyc;
                done_cnt_a++;
            end
`ifdef VMEM_LOADER_CHECKSUM_EN
            if (done_a) cs_done_a = cs_a;
            if (done_b) cs_done_b = cs_b;
`endif
        end
        prev_busy_a = busy_a;
        cyc++;
    end

    task automatic step(input logic s, input logic ab, input logic we);
        @(posedge clk);
        #1;
        start = s;
        abort = ab;
        wr_en = we;
    endtask

    initial begin
        int dcnt;
        #2 rst = 1'b0;
        #2;
        chk("reset_rom_ad", rom_ad_a, 0);
        chk("reset_ram_data", ram_data_b, 0);
        chk("reset_done", done_a, 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        step(0, 0, 1);

        // full copy, with an ignored start in the middle
        wq.delete(); wqb.delete();
        b_ff = 1'b1;
        step(1, 0, 1);
        for (int j = 1; j <= 24; j++) begin
            step(j == 5, 0, 1);
            if (j == 6) begin
                #1;
                chk("busy_after_ignored_start", busy_a, 1);
            end
        end
        chk("full_writes", wq.size(), 8);
        for (int i = 0; i < wq.size(); i++) begin
            chk("full_addr", wq[i].a, i);
            chk("full_data", wq[i].d, 16 + i);
            if (i > 0) chk("full_spacing", wq[i].c - wq[i-1].c, 2);
        end
        chk("full_done_delay", done_at_a - rise_a, 16);
        chk("lat3_writes", wqb.size(), 4);
        for (int i = 1; i < wqb.size(); i++) chk("lat3_spacing", wqb[i].c - wqb[i-1].c, 4);
`ifdef VMEM_LOADER_CHECKSUM_EN
        chk("checksum_ff", cs_done_b, 16'h03FC);
        chk("checksum_ramp", cs_done_a, 16'h009C);
`endif

        // write permit low for three cycles while word 2 sits in WRITE
        b_ff = 1'b0;
        wq.delete();
        step(1, 0, 1);
        for (int j = 1; j <= 24; j++) step(0, 0, !(j >= 6 && j <= 8));
        chk("gate_writes", wq.size(), 8);
        if (wq.size() == 8) chk("gate_gap", wq[2].c - wq[1].c, 5);
        chk("gate_done_delay", done_at_a - rise_a, 19);

        // abort while word 4 is in WRITE, then restart from 0
        wq.delete();
        dcnt = done_cnt_a;
        step(1, 0, 1);
        for (int j = 1; j <= 10; j++) step(0, j == 10, 1);
        step(0, 0, 1);
        #1;
        chk("abort_idle", busy_a, 0);
        chk("abort_writes", wq.size(), 4);
        if (wq.size() > 0) chk("abort_last_addr", wq[wq.size()-1].a, 3);
        chk("abort_no_done", done_cnt_a, dcnt);
        wq.delete();
        step(1, 0, 1);
        for (int j = 1; j <= 22; j++) step(0, 0, 1);
        chk("restart_writes", wq.size(), 8);
        if (wq.size() > 0) chk("restart_first_addr", wq[0].a, 0);
        chk("restart_done", done_cnt_a, dcnt + 1);

        // start together with abort in IDLE is ignored
        step(1, 1, 1);
        step(0, 0, 1);
        #1;
        chk("start_abort_busy_a", busy_a, 0);
        chk("start_abort_busy_b", busy_b, 0);

        // asynchronous reset in the middle of a copy
        step(1, 0, 1);
        for (int j = 1; j <= 7; j++) step(0, 0, 1);
        #1 rst = 1'b0;
        #1;
        chk("midrst_busy", busy_a, 0);
        chk("midrst_rom_ad", rom_ad_a, 0);
        chk("midrst_ram_ad", ram_ad_a, 0);
        chk("midrst_ram_data", ram_data_a, 0);
        chk("midrst_ce", ce_b, 0);
        chk("midrst_busy_b", busy_b, 0);
`ifdef VMEM_LOADER_CHECKSUM_EN
        chk("midrst_checksum", cs_a, 0);
`endif
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;

        // randomized traffic
        for (int j = 0; j < 3000; j++) begin
            step($urandom_range(5) == 0, $urandom_range(49) == 0, $urandom_range(3) != 0);
        end
        step(0, 0, 1);
        step(0, 0, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vmem_loader.md
# vmem_loader

Sequencer that copies an image from the image ROM into the video RAM write port, one word at a time, on a start command. Sits between `image_rom` and the write side of `video_ram`; it owns the ROM address, the RAM write enable, address and data. It gates writes with an external permit so that loading can be restricted to display blanking.

## Interface
- `ADDR_W`, 11: RAM/ROM word-address width.
- `DATA_W`, 8: data width.
- `LAST_ADDR`, 2047: final address copied; the copy always starts at 0. Must be < 2**ADDR_W.
- `ROM_LATENCY`, 1: cycles from `rom_ad_o` change to valid `rom_data_i`. Must be ≥ 1.

Ports:
- `clk`  in  1  single clock; ROM and RAM write port run on it.
- `rst`  in  1  asynchronous, active-low reset.
- `start_i`  in  1  level; sampled in IDLE only.
- `abort_i`  in  1  level; cancels a copy in progress.
- `wr_en_i`  in  1  write permit (e.g. blanking); high = RAM write allowed this cycle.
- `rom_ad_o`  out  ADDR_W  ROM read address.
- `rom_data_i`  in  DATA_W  ROM read data.
- `ram_ce_o`  out  1  RAM write strobe.
- `ram_ad_o`  out  ADDR_W  RAM write address.
- `ram_data_o`  out  DATA_W  RAM write data.
- `busy_o`  out  1  high in FETCH and WRITE.
- `done_o`  out  1  one-cycle pulse on normal completion.

## Operation
- States: IDLE, FETCH, WRITE, DONE.
- Reset values: state IDLE; `addr` = 0; latency counter = 0; data register = 0. All outputs are therefore 0.
- IDLE: if `start_i` is high and `abort_i` is low, load `addr` = 0 and the counter = ROM_LATENCY, then go to FETCH. Otherwise stay in IDLE.
- FETCH: `rom_ad_o` = `addr` and the counter decrements each cycle. In the cycle the counter reaches 1, latch `rom_data_i` into the data register and go to WRITE.
- WRITE: `ram_ce_o` = `wr_en_i`, combinational; `ram_ad_o` = `addr`; `ram_data_o` = data register.
  - While `wr_en_i` is low, stay in WRITE and hold every value.
  - On a write cycle with `addr` == LAST_ADDR, go to DONE.
  - On any other write cycle, increment `addr`, reload the counter and go to FETCH.
- DONE: `done_o` = 1 for this cycle only, then go to IDLE.
- `abort_i` high in FETCH or WRITE: go to IDLE next cycle.
  - `ram_ce_o` is forced to 0 in that cycle.
  - No `done_o` pulse is produced.
  - RAM contents already written are left as they are.
- `abort_i` has priority over `start_i`, and over completion when both occur in the same cycle.
- `start_i` is ignored in FETCH, WRITE and DONE; it is not queued.
- `addr` never wraps; the copy stops at LAST_ADDR.
- Outside WRITE: `ram_ce_o` = 0 and `ram_ad_o`/`ram_data_o` hold their last values. `rom_ad_o` holds `addr`.

## Timing
- Start latency: 1 cycle; `busy_o` rises the cycle after `start_i` is sampled.
- With `wr_en_i` held high, each word takes ROM_LATENCY + 1 cycles.
- A full copy takes (LAST_ADDR+1)·(ROM_LATENCY+1) busy cycles, followed by 1 DONE cycle.
- `busy_o` falls in the DONE cycle.
- A new start is accepted at the earliest in the cycle after DONE.
- Every `wr_en_i` low cycle spent in WRITE adds exactly one cycle.
- The counter is $clog2(ROM_LATENCY+1) bits wide. `addr` is ADDR_W bits, unsigned.

## Configuration
- `VMEM_LOADER_CHECKSUM_EN` defined: adds output `checksum_o` [15:0].
  - Cleared to 0 on reset and on start acceptance.
  - On each `ram_ce_o` cycle it adds zero-extended `ram_data_o`, mod 2^16.
  - It is valid while `done_o` is high and holds until the next start.
- Not defined: the port and its logic are absent; all other behaviour is identical.

## Structure
- Package `vmem_pkg` holds:
  - the state enum `vmem_ld_state_t` (IDLE, FETCH, WRITE, DONE);
  - the default constants `VMEM_ADDR_W` = 11 and `VMEM_DATA_W` = 8.
- One sub-module: `vmem_checksum`, the 16-bit accumulator. It is instantiated only under `VMEM_LOADER_CHECKSUM_EN`.
- The FSM, address counter and latency counter stay in `vmem_loader`.

## Test plan
- **Full copy.** Setup: LAST_ADDR=7, ROM_LATENCY=1, ROM data = addr+0x10, `wr_en_i`=1, pulse `start_i`. Required: 8 writes with `ram_ad_o` 0..7 and data 0x10..0x17, spaced 2 cycles apart; `done_o` 16 cycles after `busy_o` rises.
- **Write gating.** Setup: `wr_en_i` low for 3 cycles during WRITE at addr 2. Required: `ram_ce_o` stays 0 and addr/data are held; completion is delayed by exactly 3 cycles.
- **Abort.** Setup: `abort_i` asserted in the WRITE state at addr 4, with `wr_en_i`=1. Required: no write to addr 4, no `done_o`, IDLE the next cycle. A following `start_i` restarts from addr 0.
- **Start priority.** Setup: `start_i` while busy, and `start_i`+`abort_i` together in IDLE. Required: both are ignored; `busy_o` stays unchanged.
- **Mid-copy reset.** Setup: assert `rst`=0 in FETCH. Required: all outputs are 0 immediately, without waiting for a clock edge. Setup: ROM_LATENCY=3. Required: writes are spaced 4 cycles apart.
- **Checksum.** Setup: `VMEM_LOADER_CHECKSUM_EN` defined, LAST_ADDR=3, data 0xFF each word. Required: `checksum_o` = 0x03FC at `done_o`.
